// File: rtl/miai_alu_pkg.sv
// Package: miai_alu_pkg
// Shared opcode and FSM state encodings for the bit-serial ALU sequencer,
// plus a helper that classifies opcodes as arithmetic (carry-chained).
package miai_alu_pkg;

    localparam int unsigned OPCODE_W = 3;

    // Opcodes understood by the 1-bit ALU slice; other encodings act as logic ops.
    typedef enum logic [OPCODE_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100
    } opcode_e;

    // Sequencer states: accept, stream bits, present result.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // True for opcodes that chain carry between bits.
    function automatic logic is_arith(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/miai_shift_reg.sv
// Module: miai_shift_reg
// Parallel-load, right-shift register. Load has priority over shift; the
// serial input enters at the MSB so an LSB-first stream lands in order.
module miai_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_shift_in,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Parallel load or one-bit right shift per enabled clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {i_shift_in, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/miai_alu_serial_seq.sv
// Module: miai_alu_serial_seq
// Bit-serial operand sequencer and result collector for a combinational 1-bit
// ALU slice. Accepts one WIDTH-bit operation, streams it LSB-first through the
// ALU while chaining carry, then presents result/carry/zero on a handshake.
// Optional feature: define MIAI_ALU_SEQ_OVF_EN to add the signed-overflow
// output ovf (carry into MSB xor carry out of MSB, ADD/SUB only).
module miai_alu_serial_seq
    import miai_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                alu_a,
    output logic                alu_b,
    output logic                alu_cin,
    output logic [OPCODE_W-1:0] alu_op,
    input  logic                alu_y,
    input  logic                alu_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                carry_out,
    output logic                zero
`ifdef MIAI_ALU_SEQ_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e              r_state;
    logic [OPCODE_W-1:0] r_op;
    logic                r_cin;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_carry_out;
    logic                r_zero;
`ifdef MIAI_ALU_SEQ_OVF_EN
    logic                r_ovf;
`endif

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_arith;
    logic             w_carry;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_res_q;
    logic [WIDTH-1:0] w_res_next;
    logic             w_unused;

    assign w_accept   = r_in_ready & in_valid;
    assign w_run      = (r_state == S_RUN);
    assign w_last     = w_run && (r_cnt == LAST_CNT);
    assign w_arith    = is_arith(r_op);
    // Logic ops never propagate carry, whatever the ALU reports on alu_cout.
    assign w_carry    = w_arith & alu_cout;
    assign w_res_next = {alu_y, w_res_q[WIDTH-1:1]};

    // Operand registers only ever expose their LSB; upper bits just shift down.
    assign w_unused = &{1'b0, w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

    miai_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_data (op_a),
        .i_shift     (w_run),
        .i_shift_in  (1'b0),
        .o_q         (w_a_q)
    );

    miai_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_data (op_b),
        .i_shift     (w_run),
        .i_shift_in  (1'b0),
        .o_q         (w_b_q)
    );

    // Result collector: ALU bits enter at the MSB, so after WIDTH shifts bit 0 is at the LSB.
    miai_shift_reg #(.WIDTH(WIDTH)) u_shift_res (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_data ('0),
        .i_shift     (w_run),
        .i_shift_in  (alu_y),
        .o_q         (w_res_q)
    );

    // Sequencer FSM: IDLE accepts, RUN streams WIDTH bits, DONE holds until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
`ifdef MIAI_ALU_SEQ_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= opcode;
                        // Subtract is a + ~b + 1: the ALU inverts b, we supply the +1.
                        r_cin       <= (opcode == OP_SUB);
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b0;
                        r_carry_out <= 1'b0;
                        r_zero      <= 1'b0;
`ifdef MIAI_ALU_SEQ_OVF_EN
                        r_ovf       <= 1'b0;
`endif
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cin <= w_carry;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_carry_out <= w_carry;
                        r_zero      <= (w_res_next == '0);
`ifdef MIAI_ALU_SEQ_OVF_EN
                        // r_cin still holds the carry into the MSB during the last bit.
                        r_ovf       <= w_arith & (r_cin ^ alu_cout);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ALU drive is quiet outside RUN so the slice sees all-zero inputs when idle.
    assign alu_a     = w_run & w_a_q[0];
    assign alu_b     = w_run & w_b_q[0];
    assign alu_cin   = w_run & r_cin;
    assign alu_op    = w_run ? r_op : '0;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = w_res_q;
    assign carry_out = r_carry_out;
    assign zero      = r_zero;
`ifdef MIAI_ALU_SEQ_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
